// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for a Fibonacci LFSR serial stream.
// Self-synchronises on the incoming bits, then free-runs a local LFSR and flags mismatches.
module lfsr_checker #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] TAPS      = 'h09,
  parameter int               LOCK_CNT  = 8,
  parameter int               WINDOW    = 32,
  parameter int               ERR_LIMIT = 4,
  parameter int               CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_bit,
  input  logic            clr_cnt,
  output logic            locked,
  output logic            err,
  output logic [CNTW-1:0] err_count,
  output logic [CNTW-1:0] bit_count
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LIM_V  = EW'(ERR_LIMIT);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] win, win_n;
  logic [FW-1:0]    fill, fill_n;
  logic [MW-1:0]    match, match_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic [EW-1:0]    werr, werr_n, werr_sum;
  logic             pred, mism;
  logic             err_n, err_inc, bit_inc;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v,
                                               input logic            inc,
                                               input logic            clr);
    if (clr) return '0;
    if (inc && (v != '1)) return v + CNTW'(1);
    return v;
  endfunction

  assign pred     = ^(win & TAPS);
  assign mism     = in_bit ^ pred;
  assign werr_sum = werr + EW'(mism);

  always_comb begin
    state_n = state;
    win_n   = win;
    fill_n  = fill;
    match_n = match;
    wcnt_n  = wcnt;
    werr_n  = werr;
    err_n   = 1'b0;
    err_inc = 1'b0;
    bit_inc = 1'b0;
    if (in_valid) begin
      unique case (state)
        SEED: begin
          win_n = {in_bit, win[WIDTH-1:1]};
          if (fill == FILL_LAST) begin
            state_n = VERIFY;
            fill_n  = '0;
            match_n = '0;
          end else begin
            fill_n = fill + FW'(1);
          end
        end
        VERIFY: begin
          win_n = {in_bit, win[WIDTH-1:1]};
          // An all-zero window would predict zeros forever, so it never counts as a hit.
          if (!mism && (win != '0)) begin
            if (match == MATCH_LAST) begin
              state_n = LOCKED;
              match_n = '0;
              wcnt_n  = '0;
              werr_n  = '0;
            end else begin
              match_n = match + MW'(1);
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so one corrupted input bit costs one err.
          win_n   = {pred, win[WIDTH-1:1]};
          err_n   = mism;
          err_inc = mism;
          bit_inc = 1'b1;
          if (werr_sum == ERR_LIM_V) begin
            state_n = SEED;
            fill_n  = '0;
          end else if (wcnt == WIN_LAST) begin
            wcnt_n = '0;
            werr_n = '0;
          end else begin
            wcnt_n = wcnt + WW'(1);
            werr_n = werr_sum;
          end
        end
        default: state_n = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
      fill      <= '0;
      match     <= '0;
      wcnt      <= '0;
      werr      <= '0;
    end else begin
      state     <= state_n;
      locked    <= (state_n == LOCKED);
      err       <= err_n;
      err_count <= sat_inc(err_count, err_inc, clr_cnt);
      bit_count <= sat_inc(bit_count, bit_inc, clr_cnt);
      fill      <= fill_n;
      match     <= match_n;
      wcnt      <= wcnt_n;
      werr      <= werr_n;
    end
  end

  // Shift window is pure data; SEED refills it completely before it is ever used.
  always_ff @(posedge clk) begin
    win <= win_n;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed testbench for lfsr_checker: lock, single error, lock loss, zero input,
// gapped input with counter clear, and counter saturation with mid-stream reset.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err;
  logic [15:0] err_count, bit_count;
  logic        s_locked, s_err;
  logic [2:0]  s_err_count, s_bit_count;

  int tests = 0;
  int fails = 0;

  logic strm [0:1023];
  int   ptr;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count)
  );

  lfsr_checker #(.CNTW(3), .ERR_LIMIT(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(s_locked), .err(s_err), .err_count(s_err_count), .bit_count(s_bit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Generator: first 5 bits are the seed (bit 0 first), then b[n+5] = b[n] ^ b[n+3] (taps 'h09).
  task automatic gen_stream(input logic [4:0] seed);
    for (int i = 0; i < 5; i++) strm[i] = seed[i];
    for (int n = 0; n < 1019; n++) strm[n+5] = strm[n] ^ strm[n+3];
    ptr = 0;
  endtask

  task automatic step(input logic v, input logic flip, input logic c);
    in_valid = v;
    clr_cnt  = c;
    if (v) begin
      in_bit = strm[ptr] ^ flip;
      ptr++;
    end else begin
      in_bit = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; in_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", locked); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
  endtask

  task automatic test_lock();
    int rise = -1;
    int errs = 0;
    do_reset();
    gen_stream(5'h1F);
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked && rise < 0) rise = i;
      if (err) errs++;
    end
    tests++; if (rise != 13) begin fails++; $display("FAIL lock_index: got %0d expected 13", rise); end
    tests++; if (errs != 0) begin fails++; $display("FAIL lock_err_pulses: got %0d expected 0", errs); end
    tests++; if (bit_count !== 16'd187) begin fails++; $display("FAIL lock_bit_count: got %0d expected 187", bit_count); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL lock_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    do_reset();
    gen_stream(5'h1F);
    repeat (13) step(1'b1, 1'b0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL single_prelock: got %b expected 1", locked); end
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, (i == 10), 1'b0);
      if (i == 10) begin
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL single_err_latency: got %b expected 1", err); end
      end
      if (err) pulses++;
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL single_locked: got %b expected 1", locked); end
  endtask

  task automatic test_lock_loss();
    int drop = -1;
    int relock = -1;
    do_reset();
    gen_stream(5'h1F);
    repeat (13) step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, (i == 2 || i == 5 || i == 8 || i == 11), 1'b0);
      if (!locked && drop < 0) drop = i;
      if (locked && drop >= 0 && relock < 0) relock = i;
    end
    tests++; if (drop != 11) begin fails++; $display("FAIL loss_drop_index: got %0d expected 11", drop); end
    tests++; if (relock != 24) begin fails++; $display("FAIL loss_relock_index: got %0d expected 24", relock); end
    tests++; if (err_count !== 16'd4) begin fails++; $display("FAIL loss_err_count: got %0d expected 4", err_count); end
  endtask

  task automatic test_all_zero();
    int lk = 0;
    do_reset();
    gen_stream(5'h00);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) lk++;
    end
    tests++; if (lk != 0) begin fails++; $display("FAIL zero_locked_cycles: got %0d expected 0", lk); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL zero_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_gaps_clear();
    int vc = 0;
    int rise = -1;
    logic v;
    do_reset();
    gen_stream(5'h1F);
    for (int c = 0; c < 300 && vc < 40; c++) begin
      v = 1'($urandom_range(0, 1));
      step(v, 1'b0, 1'b0);
      if (v) vc++;
      if (locked && rise < 0) rise = vc;
    end
    tests++; if (rise != 13) begin fails++; $display("FAIL gaps_lock_index: got %0d expected 13", rise); end
    step(1'b1, 1'b1, 1'b0);
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL gaps_err_count: got %0d expected 1", err_count); end
    step(1'b1, 1'b1, 1'b1);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL clear_err_pulse: got %b expected 1", err); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL clear_err_count: got %0d expected 0", err_count); end
    tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL clear_bit_count: got %0d expected 0", bit_count); end
    step(1'b1, 1'b0, 1'b0);
    tests++; if (bit_count !== 16'd1) begin fails++; $display("FAIL clear_bit_after: got %0d expected 1", bit_count); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clear_locked: got %b expected 1", locked); end
  endtask

  task automatic test_sat_reset();
    do_reset();
    gen_stream(5'h1F);
    repeat (13) step(1'b1, 1'b0, 1'b0);
    tests++; if (s_locked !== 1'b1) begin fails++; $display("FAIL sat_prelock: got %b expected 1", s_locked); end
    repeat (10) step(1'b1, 1'b1, 1'b0);
    tests++; if (s_err_count !== 3'd7) begin fails++; $display("FAIL sat_err_count: got %0d expected 7", s_err_count); end
    tests++; if (s_bit_count !== 3'd7) begin fails++; $display("FAIL sat_bit_count: got %0d expected 7", s_bit_count); end
    tests++; if (s_err !== 1'b1) begin fails++; $display("FAIL sat_err_pulse: got %b expected 1", s_err); end
    tests++; if (s_locked !== 1'b1) begin fails++; $display("FAIL sat_locked: got %b expected 1", s_locked); end
    rst = 1'b1;
    in_valid = 1'b1;
    in_bit = ~strm[ptr];
    @(posedge clk);
    #1;
    tests++; if ({s_locked, s_err, s_err_count, s_bit_count} !== 8'd0) begin
      fails++; $display("FAIL sat_midreset: got %b/%b/%0d/%0d expected 0/0/0/0", s_locked, s_err, s_err_count, s_bit_count);
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_lock_loss();
    test_all_zero();
    test_gaps_clear();
    test_sat_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
